// File: rtl/fir_out_capture.sv
// Capture sink for the FIR output stream: skips SKIP leading samples, stores DEPTH samples in RAM,
// then serves registered random-access reads. Optional min/max tracking under FIR_CAP_MINMAX_EN.
module fir_out_capture #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1000,
  parameter int SKIP  = 0,
  localparam int DW   = WIDTH + 3,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_data,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [AW:0]          count,
  input  logic                 rd_en,
  input  logic [AW-1:0]        rd_addr,
  output logic [DW-1:0]        rd_data,
  output logic                 rd_valid
`ifdef FIR_CAP_MINMAX_EN
  ,
  output logic signed [DW-1:0] min_val,
  output logic signed [DW-1:0] max_val
`endif
);

  localparam int SW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
  localparam logic [SW-1:0] SKIP_LAST = (SKIP > 0) ? SW'(SKIP - 1) : '0;
  localparam logic [AW:0]   CNT_LAST  = (AW + 1)'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SKIP    = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t          state_r;
  logic [SW-1:0]   skip_cnt_r;
  logic [AW-1:0]   wr_ptr_r;
  logic [DW-1:0]   mem [0:DEPTH-1];
  logic            wr_en_s;
  logic            arm_s;

  // abort suppresses the write of a sample arriving in the same cycle
  assign wr_en_s = (state_r == S_CAPTURE) && in_valid && !abort;
  assign arm_s   = ((state_r == S_IDLE) || (state_r == S_DONE)) && start && !abort;

  // Capture control FSM with registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      count      <= '0;
      skip_cnt_r <= '0;
      wr_ptr_r   <= '0;
    end else if (abort) begin
      state_r <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) begin
            count      <= '0;
            wr_ptr_r   <= '0;
            skip_cnt_r <= '0;
            done       <= 1'b0;
            busy       <= 1'b1;
            state_r    <= (SKIP == 0) ? S_CAPTURE : S_SKIP;
          end
        end
        S_SKIP: begin
          if (in_valid) begin
            skip_cnt_r <= skip_cnt_r + SW'(1);
            if (skip_cnt_r == SKIP_LAST) begin
              state_r <= S_CAPTURE;
            end
          end
        end
        S_CAPTURE: begin
          if (in_valid) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
            count    <= count + (AW + 1)'(1);
            if (count == CNT_LAST) begin
              state_r <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  // Sample RAM, not cleared by reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[wr_ptr_r] <= in_data;
    end
  end

  // Registered read port, only serviced while no capture is running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (rd_en && !busy) begin
      rd_valid <= 1'b1;
      rd_data  <= ({1'b0, rd_addr} < DEPTH_CNT) ? mem[rd_addr] : '0;
    end else begin
      rd_valid <= 1'b0;
    end
  end

`ifdef FIR_CAP_MINMAX_EN
  localparam logic signed [DW-1:0] MAX_POS = {1'b0, {(DW - 1){1'b1}}};
  localparam logic signed [DW-1:0] MAX_NEG = {1'b1, {(DW - 1){1'b0}}};

  // Running signed extremes of the stored samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_val <= '0;
      max_val <= '0;
    end else if (abort) begin
      min_val <= '0;
      max_val <= '0;
    end else if (arm_s) begin
      min_val <= MAX_POS;
      max_val <= MAX_NEG;
    end else if (wr_en_s) begin
      if (in_data < min_val) begin
        min_val <= in_data;
      end
      if (in_data > max_val) begin
        max_val <= in_data;
      end
    end
  end
`else
  logic unused_arm_s;
  assign unused_arm_s = arm_s;
`endif

endmodule

// File: tb/tb_fir_out_capture.sv
// Scoreboard bench for fir_out_capture: DUT a (DEPTH=8, SKIP=0) and DUT b (DEPTH=5, SKIP=3).
module tb_fir_out_capture;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_in_valid, a_start, a_abort, a_busy, a_done, a_rd_en, a_rd_valid;
  logic [18:0] a_in_data, a_rd_data;
  logic [3:0]  a_count;
  logic [2:0]  a_rd_addr;
  logic        b_in_valid, b_start, b_abort, b_busy, b_done, b_rd_en, b_rd_valid;
  logic [18:0] b_in_data, b_rd_data;
  logic [3:0]  b_count;
  logic [2:0]  b_rd_addr;
`ifdef FIR_CAP_MINMAX_EN
  logic [18:0] a_min, a_max, b_min, b_max;
`endif

  int errors = 0;
  int checks = 0;
  logic [18:0] qa[$];
  logic [18:0] qb[$];

  fir_out_capture #(.WIDTH(16), .DEPTH(8), .SKIP(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_data(a_in_data),
    .start(a_start), .abort(a_abort), .busy(a_busy), .done(a_done), .count(a_count),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid)
`ifdef FIR_CAP_MINMAX_EN
    , .min_val(a_min), .max_val(a_max)
`endif
  );

  fir_out_capture #(.WIDTH(16), .DEPTH(5), .SKIP(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data),
    .start(b_start), .abort(b_abort), .busy(b_busy), .done(b_done), .count(b_count),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid)
`ifdef FIR_CAP_MINMAX_EN
    , .min_val(b_min), .max_val(b_max)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One valid sample, then `gap` idle cycles with junk data on the bus
  task automatic send(input bit sel, input logic [18:0] d, input int gap);
    if (!sel) begin a_in_valid = 1'b1; a_in_data = d; end
    else begin b_in_valid = 1'b1; b_in_data = d; end
    tick();
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    a_in_data = 19'h7ABCD; b_in_data = 19'h7ABCD;
    repeat (gap) tick();
  endtask

  task automatic pulse(input bit sel, input bit st, input bit ab);
    if (!sel) begin a_start = st; a_abort = ab; end
    else begin b_start = st; b_abort = ab; end
    tick();
    a_start = 1'b0; a_abort = 1'b0; b_start = 1'b0; b_abort = 1'b0;
  endtask

  // Issue one accepted read and queue its expected data; rd_en left high for back-to-back use
  task automatic rd(input bit sel, input int addr, input logic [18:0] exp);
    if (!sel) begin a_rd_en = 1'b1; a_rd_addr = 3'(addr); qa.push_back(exp); end
    else begin b_rd_en = 1'b1; b_rd_addr = 3'(addr); qb.push_back(exp); end
    tick();
  endtask

  // Monitor: every presented read result is matched against the scoreboard
  always @(negedge clk) begin
    if (a_rd_valid) begin
      if (qa.size() == 0) check("a_unexpected_rd_valid", 32'(a_rd_valid), 32'd0);
      else check("a_rd_data", 32'(a_rd_data), 32'(qa.pop_front()));
    end
    if (b_rd_valid) begin
      if (qb.size() == 0) check("b_unexpected_rd_valid", 32'(b_rd_valid), 32'd0);
      else check("b_rd_data", 32'(b_rd_data), 32'(qb.pop_front()));
    end
  end

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_start = 1'b0; a_abort = 1'b0; a_rd_en = 1'b0; a_rd_addr = '0;
    b_in_valid = 1'b0; b_in_data = '0; b_start = 1'b0; b_abort = 1'b0; b_rd_en = 1'b0; b_rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    check("rst_count", 32'(a_count), 32'd0);
    check("rst_rd_valid", 32'(a_rd_valid), 32'd0);
    check("rst_rd_data", 32'(a_rd_data), 32'd0);
    check("rst_b_busy", 32'(b_busy), 32'd0);
    rst = 1'b0;
    tick();

    // Basic capture of 1..8, with an ignored start mid-capture
    pulse(1'b0, 1'b1, 1'b0);
    check("t1_busy", 32'(a_busy), 32'd1);
    check("t1_count0", 32'(a_count), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      if (i == 5) a_start = 1'b1;
      send(1'b0, 19'(i), 0);
      a_start = 1'b0;
      if (i == 5) check("t1_start_ignored", 32'(a_count), 32'd5);
      if (i == 7) check("t1_done_early", 32'(a_done), 32'd0);
    end
    check("t1_done", 32'(a_done), 32'd1);
    check("t1_busy_end", 32'(a_busy), 32'd0);
    check("t1_count", 32'(a_count), 32'd8);
    for (int i = 0; i < 8; i++) rd(1'b0, i, 19'(i + 1));
    a_rd_en = 1'b0;
    tick();
    check("t1_rd_valid_low", 32'(a_rd_valid), 32'd0);

    // Abort after 4 samples, with a rejected read while busy
    pulse(1'b0, 1'b1, 1'b0);
    check("t3_count0", 32'(a_count), 32'd0);
    check("t3_done_cleared", 32'(a_done), 32'd0);
    send(1'b0, 19'd21, 1);
    a_rd_en = 1'b1; a_rd_addr = 3'd0;
    send(1'b0, 19'd22, 0);
    a_rd_en = 1'b0;
    check("t4_busy_rd_valid", 32'(a_rd_valid), 32'd0);
    check("t4_busy_rd_hold", 32'(a_rd_data), 32'd8);
    send(1'b0, 19'd23, 0);
    send(1'b0, 19'd24, 0);
    pulse(1'b0, 1'b0, 1'b1);
    check("t3_abort_busy", 32'(a_busy), 32'd0);
    check("t3_abort_done", 32'(a_done), 32'd0);
    check("t3_abort_count", 32'(a_count), 32'd4);
    pulse(1'b0, 1'b1, 1'b0);
    check("t3_restart_count", 32'(a_count), 32'd0);
    for (int i = 0; i < 8; i++) send(1'b0, 19'(31 + i), i % 2);
    check("t3_done", 32'(a_done), 32'd1);
    check("t3_count", 32'(a_count), 32'd8);
    rd(1'b0, 2, 19'd33);
    rd(1'b0, 3, 19'd34);
    rd(1'b0, 0, 19'd31);
    a_rd_en = 1'b0;
    tick();

    // Asynchronous reset between edges, then start+abort together
    pulse(1'b0, 1'b1, 1'b0);
    send(1'b0, 19'd41, 0);
    send(1'b0, 19'd42, 0);
    send(1'b0, 19'd43, 0);
    check("t5_count_pre", 32'(a_count), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("t5_async_busy", 32'(a_busy), 32'd0);
    check("t5_async_count", 32'(a_count), 32'd0);
    check("t5_async_rd_data", 32'(a_rd_data), 32'd0);
    check("t5_async_done", 32'(a_done), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    pulse(1'b0, 1'b1, 1'b1);
    check("t5_start_abort_busy", 32'(a_busy), 32'd0);
    check("t5_start_abort_done", 32'(a_done), 32'd0);

    // Signed samples; RAM dump is identical with or without min/max tracking
    pulse(1'b0, 1'b1, 1'b0);
`ifdef FIR_CAP_MINMAX_EN
    check("t6_min_init", 32'(a_min), 32'h3FFFF);
    check("t6_max_init", 32'(a_max), 32'h40000);
`endif
    send(1'b0, 19'(-5), 0);
    send(1'b0, 19'd7, 1);
    send(1'b0, 19'(-32768), 0);
    send(1'b0, 19'd3, 0);
`ifdef FIR_CAP_MINMAX_EN
    check("t6_min", 32'(a_min), 32'h78000);
    check("t6_max", 32'(a_max), 32'd7);
`endif
    pulse(1'b0, 1'b0, 1'b1);
`ifdef FIR_CAP_MINMAX_EN
    check("t6_min_abort", 32'(a_min), 32'd0);
    check("t6_max_abort", 32'(a_max), 32'd0);
`endif
    check("t6_count_hold", 32'(a_count), 32'd4);
    rd(1'b0, 0, 19'(-5));
    rd(1'b0, 1, 19'd7);
    rd(1'b0, 2, 19'(-32768));
    rd(1'b0, 3, 19'd3);
    a_rd_en = 1'b0;
    tick();

    // SKIP=3 with gaps: 10,11,12 discarded, 13..17 stored
    pulse(1'b1, 1'b1, 1'b0);
    check("t2_busy", 32'(b_busy), 32'd1);
    send(1'b1, 19'd10, 1);
    send(1'b1, 19'd11, 2);
    send(1'b1, 19'd12, 0);
    check("t2_skip_count", 32'(b_count), 32'd0);
    check("t2_skip_busy", 32'(b_busy), 32'd1);
    send(1'b1, 19'd13, 1);
    send(1'b1, 19'd14, 0);
    send(1'b1, 19'd15, 1);
    send(1'b1, 19'd16, 0);
    check("t2_busy_pre", 32'(b_busy), 32'd1);
    check("t2_count_pre", 32'(b_count), 32'd4);
    send(1'b1, 19'd17, 0);
    check("t2_done", 32'(b_done), 32'd1);
    check("t2_count", 32'(b_count), 32'd5);
    for (int i = 0; i < 5; i++) rd(1'b1, i, 19'(13 + i));
    for (int i = 5; i < 8; i++) rd(1'b1, i, 19'd0);
    b_rd_en = 1'b0;
    tick();
    tick();

    check("qa_drained", 32'(qa.size()), 32'd0);
    check("qb_drained", 32'(qb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
